// File: rtl/xcom_pkg.sv
// Shared XCOM link definitions: header fields, size codes, packet sizing helpers.
package xcom_pkg;

    localparam int unsigned HDR_W      = 8;
    localparam int unsigned HDR_SZ_LSB = 5;
    localparam int unsigned HDR_SZ_MSB = 6;

    typedef enum logic [1:0] {
        XCOM_SZ_NONE = 2'd0,
        XCOM_SZ_8    = 2'd1,
        XCOM_SZ_16   = 2'd2,
        XCOM_SZ_32   = 2'd3
    } xcom_sz_e;

    typedef enum logic [1:0] {
        XCOM_TX_IDLE = 2'd0,
        XCOM_TX_LOAD = 2'd1,
        XCOM_TX_SYM  = 2'd2,
        XCOM_TX_DONE = 2'd3
    } xcom_tx_state_e;

    // Payload width for a size code, clamped to the configured maximum.
    function automatic int unsigned payload_bits(input xcom_sz_e code, input int unsigned dw);
        int unsigned w;
        case (code)
            XCOM_SZ_NONE: w = 0;
            XCOM_SZ_8:    w = 8;
            XCOM_SZ_16:   w = 16;
            default:      w = 32;
        endcase
        return (w > dw) ? dw : w;
    endfunction

    // Symbols for len bits over nlane wires, rounded to even so the strobe idles low.
    function automatic int unsigned sym_count(input int unsigned len, input int unsigned nlane);
        int unsigned s;
        s = (len + nlane - 1) / nlane;
        if ((s % 2) != 0) begin
            s = s + 1;
        end
        return s;
    endfunction

endpackage

// File: rtl/xcom_tick_gen.sv
// Symbol period counter: flags the last cycle of each symbol and the mid-symbol strobe point.
module xcom_tick_gen #(
    parameter int unsigned TICK_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [TICK_W-1:0] period_i,
    output logic              sym_start_c,
    output logic              ck_tgl_c
);

    logic [TICK_W-1:0] cnt_q;
    logic [TICK_W-1:0] cnt_d;

    // period_i is at least 2, so the half-period point is always a valid count.
    always_comb begin
        sym_start_c = en_i && (cnt_q == (period_i - TICK_W'(1)));
        ck_tgl_c    = en_i && (cnt_q == ((period_i >> 1) - TICK_W'(1)));
        cnt_d       = cnt_q + TICK_W'(1);
        if (!en_i || sym_start_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/xcom_link_tx_mlane.sv
// Multi-lane XCOM link transmitter: serialises header+payload(+parity) MSB-first
// across NLANE data wires with a strobe that toggles once per symbol.
module xcom_link_tx_mlane
    import xcom_pkg::*;
#(
    parameter int unsigned NLANE  = 1,
    parameter int unsigned DW     = 32,
    parameter int unsigned TICK_W = 4
) (
    input  logic              x_clk_i,
    input  logic              x_rst_i,
    input  logic [TICK_W-1:0] tick_cfg_i,
    input  logic              parity_en_i,
    input  logic              tx_vld_i,
    output logic              tx_rdy_o,
    input  logic [HDR_W-1:0]  tx_header_i,
    input  logic [DW-1:0]     tx_data_i,
    output logic [NLANE-1:0]  tx_dt_o,
    output logic              tx_ck_o,
    output logic              tx_busy_o,
    output logic              tx_done_o
);

    localparam int unsigned BIT_MAX = HDR_W + DW + 1;
    localparam int unsigned SYM_MAX = sym_count(BIT_MAX, NLANE);
    localparam int unsigned SYM_W   = $clog2(SYM_MAX);
    localparam int unsigned SR_W    = SYM_MAX * NLANE;

    xcom_tx_state_e state_q, state_d;

    logic              rdy_q, rdy_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ck_q, ck_d;
    logic [NLANE-1:0]  dt_q, dt_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [SYM_W-1:0]  last_q, last_d;
    logic [TICK_W-1:0] per_q, per_d;

    logic              accept_c;
    logic              tick_en_c;
    logic              sym_start_c;
    logic              ck_tgl_c;
    int unsigned       pw_c;
    int unsigned       len_c;
    logic              par_c;
    logic [BIT_MAX-1:0] pay_c;
    logic [BIT_MAX-1:0] bits_c;
    logic [SR_W-1:0]   sr_load_c;
    logic [SYM_W-1:0]  last_load_c;
    logic [TICK_W-1:0] per_load_c;

    assign accept_c  = tx_vld_i && rdy_q;
    assign tick_en_c = (state_q == XCOM_TX_LOAD) || (state_q == XCOM_TX_SYM);

    xcom_tick_gen #(
        .TICK_W (TICK_W)
    ) u_tick (
        .clk_i       (x_clk_i),
        .rst_i       (x_rst_i),
        .en_i        (tick_en_c),
        .period_i    (per_q),
        .sym_start_c (sym_start_c),
        .ck_tgl_c    (ck_tgl_c)
    );

    // Packet assembly from the live inputs; only used on the accept cycle.
    always_comb begin
        pw_c   = payload_bits(xcom_sz_e'(tx_header_i[HDR_SZ_MSB:HDR_SZ_LSB]), DW);
        pay_c  = BIT_MAX'(tx_data_i) & ((BIT_MAX'(1) << pw_c) - BIT_MAX'(1));
        par_c  = ^{tx_header_i, pay_c};
        bits_c = (BIT_MAX'(tx_header_i) << pw_c) | pay_c;
        len_c  = HDR_W + pw_c + {31'd0, parity_en_i};
        if (parity_en_i) begin
            bits_c = (bits_c << 1) | BIT_MAX'(par_c);
        end
        sr_load_c   = SR_W'(bits_c) << (SR_W - len_c);
        last_load_c = SYM_W'(sym_count(len_c, NLANE) - 1);
        per_load_c  = (tick_cfg_i < TICK_W'(2)) ? TICK_W'(2) : tick_cfg_i;
    end

    always_ff @(posedge x_clk_i) begin
        if (x_rst_i) begin
            state_q <= XCOM_TX_IDLE;
            rdy_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ck_q    <= 1'b0;
            dt_q    <= '0;
            sr_q    <= '0;
            sym_q   <= '0;
            last_q  <= '0;
            per_q   <= TICK_W'(2);
        end else begin
            state_q <= state_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ck_q    <= ck_d;
            dt_q    <= dt_d;
            sr_q    <= sr_d;
            sym_q   <= sym_d;
            last_q  <= last_d;
            per_q   <= per_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            XCOM_TX_IDLE: if (accept_c) state_d = XCOM_TX_LOAD;
            XCOM_TX_LOAD: state_d = XCOM_TX_SYM;
            XCOM_TX_SYM:  if (sym_start_c && (sym_q == last_q)) state_d = XCOM_TX_DONE;
            XCOM_TX_DONE: state_d = accept_c ? XCOM_TX_LOAD : XCOM_TX_IDLE;
            default:      state_d = XCOM_TX_IDLE;
        endcase
    end

    // Symbol 0 is presented straight from the accept edge; later symbols shift out of sr_q.
    always_comb begin
        rdy_d  = rdy_q;
        busy_d = busy_q;
        done_d = 1'b0;
        ck_d   = ck_q;
        dt_d   = dt_q;
        sr_d   = sr_q;
        sym_d  = sym_q;
        last_d = last_q;
        per_d  = per_q;
        case (state_q)
            XCOM_TX_IDLE, XCOM_TX_DONE: begin
                rdy_d  = 1'b1;
                busy_d = 1'b0;
                ck_d   = 1'b0;
                dt_d   = '0;
                if (accept_c) begin
                    rdy_d  = 1'b0;
                    busy_d = 1'b1;
                    dt_d   = sr_load_c[SR_W-1 -: NLANE];
                    sr_d   = sr_load_c << NLANE;
                    sym_d  = '0;
                    last_d = last_load_c;
                    per_d  = per_load_c;
                end
            end
            XCOM_TX_LOAD, XCOM_TX_SYM: begin
                if (ck_tgl_c) begin
                    ck_d = ~ck_q;
                end
                if (sym_start_c) begin
                    if (sym_q == last_q) begin
                        dt_d   = '0;
                        done_d = 1'b1;
                        rdy_d  = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        sym_d = sym_q + SYM_W'(1);
                        dt_d  = sr_q[SR_W-1 -: NLANE];
                        sr_d  = sr_q << NLANE;
                    end
                end
            end
            default: ;
        endcase
    end

    assign tx_rdy_o  = rdy_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;
    assign tx_ck_o   = ck_q;
    assign tx_dt_o   = dt_q;

endmodule
